// File: rtl/spike_packer.sv
// Spike packer: collects per-neuron spike vectors from a LIF group into
// time-major words of PACK_NUM neurons, then queues them in a small
// first-word-fall-through FIFO toward the downstream consumer.
`ifndef TIME_STEPS
`define TIME_STEPS 4
`endif

module spike_packer #(
  parameter int TIME_STEPS = `TIME_STEPS,
  parameter int PACK_NUM   = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                           s_clk,
  input  logic                           s_rst,
  input  logic [TIME_STEPS-1:0]          i_spikes,
  input  logic                           i_spikes_valid,
  input  logic                           i_flush,
  output logic [TIME_STEPS*PACK_NUM-1:0] o_pack_data,
  output logic                           o_pack_valid,
  input  logic                           i_pack_ready,
  output logic                           o_overflow,
  output logic [$clog2(PACK_NUM):0]      o_fill_cnt
);

  localparam int WORD_W = TIME_STEPS * PACK_NUM;
  localparam int CNT_W  = $clog2(PACK_NUM) + 1;
  localparam int AW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CNT_W-1:0] LAST_K = CNT_W'(PACK_NUM - 1);

  // Assembly stage (p0) and FIFO stage (p1) state
  logic [WORD_W-1:0] asm_word_p0;
  logic [CNT_W-1:0]  fill_cnt_p0;
  logic [AW:0]       wr_ptr_p1;
  logic [AW:0]       rd_ptr_p1;
  logic [WORD_W-1:0] fifo_mem_p1 [FIFO_DEPTH];
  logic              overflow_p1;

  logic [WORD_W-1:0] merged_word;
  logic              last_beat;
  logic              push_req;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic              wr_ok;

  // Drop one neuron's spikes into column k of the time-major word:
  // time step t lands at bit t*PACK_NUM + k.
  function automatic logic [WORD_W-1:0] place_beat(
    input logic [WORD_W-1:0]     word,
    input logic [TIME_STEPS-1:0] spikes,
    input logic [CNT_W-1:0]      k
  );
    logic [WORD_W-1:0] w;
    w = word;
    for (int t = 0; t < TIME_STEPS; t++) begin
      w[t*PACK_NUM + int'(k)] = spikes[t];
    end
    return w;
  endfunction

  // Word assembly and push/pop decisions
  always_comb begin
    merged_word = i_spikes_valid ? place_beat(asm_word_p0, i_spikes, fill_cnt_p0)
                                 : asm_word_p0;
    last_beat   = i_spikes_valid && (fill_cnt_p0 == LAST_K);
    // A flush coinciding with the completing beat still yields a single push.
    push_req    = last_beat || (i_flush && ((fill_cnt_p0 != '0) || i_spikes_valid));
    fifo_empty  = (wr_ptr_p1 == rd_ptr_p1);
    fifo_full   = (wr_ptr_p1[AW] != rd_ptr_p1[AW]) &&
                  (wr_ptr_p1[AW-1:0] == rd_ptr_p1[AW-1:0]);
    pop         = !fifo_empty && i_pack_ready;
    // A full FIFO still accepts when the head leaves on the same edge.
    wr_ok       = push_req && (!fifo_full || pop);
  end

  // ---- p0: assembly register and fill counter ----
  always_ff @(posedge s_clk) begin
    if (s_rst) begin
      asm_word_p0 <= '0;
      fill_cnt_p0 <= '0;
    end else if (push_req) begin
      asm_word_p0 <= '0;
      fill_cnt_p0 <= '0;
    end else if (i_spikes_valid) begin
      asm_word_p0 <= merged_word;
      fill_cnt_p0 <= fill_cnt_p0 + CNT_W'(1);
    end
  end

  // ---- p1: FIFO pointers and sticky overflow ----
  always_ff @(posedge s_clk) begin
    if (s_rst) begin
      wr_ptr_p1   <= '0;
      rd_ptr_p1   <= '0;
      overflow_p1 <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr_p1 <= wr_ptr_p1 + (AW+1)'(1);
      end
      if (pop) begin
        rd_ptr_p1 <= rd_ptr_p1 + (AW+1)'(1);
      end
      if (push_req && !wr_ok) begin
        overflow_p1 <= 1'b1;
      end
    end
  end

  // FIFO storage; contents are only meaningful between the pointers
  always_ff @(posedge s_clk) begin
    if (!s_rst && wr_ok) begin
      fifo_mem_p1[wr_ptr_p1[AW-1:0]] <= merged_word;
    end
  end

  // Head of FIFO falls through; forced to zero while empty
  always_comb begin
    o_pack_valid = !fifo_empty;
    o_pack_data  = fifo_empty ? '0 : fifo_mem_p1[rd_ptr_p1[AW-1:0]];
    o_overflow   = overflow_p1;
    o_fill_cnt   = fill_cnt_p0;
  end

endmodule

// File: tb/tb_spike_packer.sv
// Bench for spike_packer: a reference packer model feeds expected words into
// a scoreboard queue; a monitor pops and compares every accepted word.
module tb_spike_packer;

  logic        s_clk;
  logic        s_rst;
  logic [3:0]  i_spikes;
  logic        i_spikes_valid;
  logic        i_flush;
  logic [63:0] o_pack_data;
  logic        o_pack_valid;
  logic        i_pack_ready;
  logic        o_overflow;
  logic [4:0]  o_fill_cnt;

  spike_packer #(.TIME_STEPS(4), .PACK_NUM(16), .FIFO_DEPTH(4)) dut (
    .s_clk          (s_clk),
    .s_rst          (s_rst),
    .i_spikes       (i_spikes),
    .i_spikes_valid (i_spikes_valid),
    .i_flush        (i_flush),
    .o_pack_data    (o_pack_data),
    .o_pack_valid   (o_pack_valid),
    .i_pack_ready   (i_pack_ready),
    .o_overflow     (o_overflow),
    .o_fill_cnt     (o_fill_cnt)
  );

  initial s_clk = 1'b0;
  always #5 s_clk = ~s_clk;

  int          n_chk = 0;
  int          n_err = 0;
  int          n_pop = 0;
  logic [63:0] exp_q [$];
  logic [63:0] m_asm;
  int          m_fill;
  logic        m_ovf;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Words leave the DUT on the edge after this sample when valid && ready.
  always @(negedge s_clk) begin
    if (!s_rst && o_pack_valid && i_pack_ready) begin
      n_pop++;
      check("sb_word_expected", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) check("sb_word", o_pack_data, exp_q.pop_front());
    end
  end

  // One cycle of stimulus plus the reference model update; called at posedge+1.
  task automatic drive(input logic [3:0] spk, input logic vld, input logic flush);
    logic [63:0] merged;
    logic        last;
    logic        push;
    i_spikes       = spk;
    i_spikes_valid = vld;
    i_flush        = flush;
    merged = m_asm;
    if (vld) for (int t = 0; t < 4; t++) merged[t*16 + m_fill] = spk[t];
    last = vld && (m_fill == 15);
    push = last || (flush && (m_fill != 0 || vld));
    if (push) begin
      if (exp_q.size() < 4 || (exp_q.size() > 0 && i_pack_ready)) exp_q.push_back(merged);
      else m_ovf = 1'b1;
      m_asm  = '0;
      m_fill = 0;
    end else if (vld) begin
      m_asm = merged;
      m_fill++;
    end
    @(posedge s_clk); #1;
    i_spikes_valid = 1'b0;
    i_flush        = 1'b0;
    i_spikes       = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge s_clk); #1; end
  endtask

  // Reset asserted together with a beat and a flush: reset must win.
  task automatic do_reset();
    s_rst = 1'b1; i_spikes = 4'hF; i_spikes_valid = 1'b1; i_flush = 1'b1;
    @(posedge s_clk); #1;
    s_rst = 1'b0; i_spikes = '0; i_spikes_valid = 1'b0; i_flush = 1'b0;
    exp_q.delete();
    m_asm = '0; m_fill = 0; m_ovf = 1'b0;
  endtask

  initial begin
    int pop0;
    s_rst = 1'b1; i_spikes = '0; i_spikes_valid = 1'b0; i_flush = 1'b0; i_pack_ready = 1'b1;
    m_asm = '0; m_fill = 0; m_ovf = 1'b0;
    repeat (2) @(posedge s_clk);
    #1; s_rst = 1'b0;

    // Reset state
    check("rst_valid", o_pack_valid, 0);
    check("rst_ovf",   o_overflow,   0);
    check("rst_fill",  o_fill_cnt,   0);
    check("rst_data",  o_pack_data,  0);

    // Flush with nothing pending does nothing
    drive(4'h0, 1'b0, 1'b1);
    check("noop_flush_valid", o_pack_valid, 0);
    check("noop_flush_fill",  o_fill_cnt,   0);

    // Full packing of 16 beats of 1010
    for (int k = 0; k < 15; k++) drive(4'b1010, 1'b1, 1'b0);
    check("full_fill15",  o_fill_cnt,   15);
    check("full_early_v", o_pack_valid, 0);
    drive(4'b1010, 1'b1, 1'b0);
    check("full_fill_wrap", o_fill_cnt,   0);
    check("full_valid",     o_pack_valid, 1);
    check("full_word",      o_pack_data,  64'hFFFF_0000_FFFF_0000);
    idle(1);
    check("full_one_cycle", o_pack_valid, 0);

    // Transposition: beat k=3 carries 0001, then flush
    for (int k = 0; k < 3; k++) drive(4'b0000, 1'b1, 1'b0);
    drive(4'b0001, 1'b1, 1'b0);
    check("trans_fill4", o_fill_cnt, 4);
    drive(4'b0000, 1'b0, 1'b1);
    check("trans_fill0", o_fill_cnt,   0);
    check("trans_valid", o_pack_valid, 1);
    check("trans_word",  o_pack_data,  64'h0000_0000_0000_0008);
    idle(1);

    // Flush coincident with the completing beat: exactly one word
    pop0 = n_pop;
    for (int k = 0; k < 15; k++) drive(4'hF, 1'b1, 1'b0);
    drive(4'hF, 1'b1, 1'b1);
    check("fl16_word", o_pack_data, 64'hFFFF_FFFF_FFFF_FFFF);
    idle(3);
    check("fl16_no_extra", o_pack_valid, 0);
    check("fl16_count",    n_pop - pop0, 1);
    check("fl16_fill",     o_fill_cnt,   0);

    // Backpressure: 5 words with ready low, the 5th is dropped
    i_pack_ready = 1'b0;
    pop0 = n_pop;
    for (int k = 0; k < 80; k++) drive(4'($urandom_range(0, 15)), 1'b1, 1'b0);
    check("bp_ovf",       o_overflow,    1);
    check("bp_ovf_model", o_overflow,    m_ovf);
    check("bp_held",      exp_q.size(),  4);
    check("bp_valid",     o_pack_valid,  1);
    idle(3);
    check("bp_stable", o_pack_data, exp_q[0]);
    i_pack_ready = 1'b1;
    idle(6);
    check("bp_drained",  n_pop - pop0, 4);
    check("bp_sb_empty", exp_q.size(), 0);
    check("bp_ovf_kept", o_overflow,   1);
    check("bp_valid_lo", o_pack_valid, 0);

    // Full FIFO popped on the edge the 5th word completes: no drop
    do_reset();
    check("rst2_ovf",   o_overflow,   0);
    check("rst2_valid", o_pack_valid, 0);
    i_pack_ready = 1'b0;
    pop0 = n_pop;
    for (int k = 0; k < 79; k++) drive(4'($urandom_range(0, 15)), 1'b1, 1'b0);
    check("fp_full", o_pack_valid, 1);
    i_pack_ready = 1'b1;
    drive(4'($urandom_range(0, 15)), 1'b1, 1'b0);
    check("fp_no_ovf", o_overflow, 0);
    idle(7);
    check("fp_delivered", n_pop - pop0, 5);
    check("fp_sb_empty",  exp_q.size(), 0);

    // Reset in the middle of a word
    for (int k = 0; k < 7; k++) drive(4'hF, 1'b1, 1'b0);
    check("mid_fill7", o_fill_cnt, 7);
    do_reset();
    check("mid_rst_fill",  o_fill_cnt,   0);
    check("mid_rst_valid", o_pack_valid, 0);
    for (int k = 0; k < 16; k++) drive(4'b0001, 1'b1, 1'b0);
    check("mid_clean_word", o_pack_data, 64'h0000_0000_0000_FFFF);
    idle(3);
    check("mid_sb_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/spike_packer.md
SPIKE_PACKER -- requirements
Module: spike_packer

Interface
REQ-001 SHALL have parameter TIME_STEPS, default `TIME_STEPS (4), the spike bits per neuron (one per time step).
REQ-002 SHALL have parameter PACK_NUM, default 16, the neurons packed per output word.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, the output FIFO word capacity (power of two).
REQ-004 SHALL have port s_clk, input, 1, the single clock; all logic SHALL be rising-edge s_clk.
REQ-005 SHALL have port s_rst, input, 1, a synchronous active-high reset.
REQ-006 SHALL have port i_spikes, input, TIME_STEPS, the per-neuron spike vector from the upstream LIF group (bit t = time step t).
REQ-007 SHALL have port i_spikes_valid, input, 1, which qualifies i_spikes; the upstream has no backpressure.
REQ-008 SHALL have port i_flush, input, 1, a single-cycle pulse that emits any partial word zero-padded.
REQ-009 SHALL have port o_pack_data, output, TIME_STEPS*PACK_NUM, the packed word at the FIFO head.
REQ-010 SHALL have port o_pack_valid, output, 1, asserted when the FIFO is non-empty.
REQ-011 SHALL have port i_pack_ready, input, 1, the downstream accept signal; a pop occurs when o_pack_valid && i_pack_ready.
REQ-012 SHALL have port o_overflow, output, 1, a sticky flag indicating a completed word was dropped.
REQ-013 SHALL have port o_fill_cnt, output, clog2(PACK_NUM)+1, the number of neurons in the current partial word.

Function
REQ-014 SHALL pack the k-th valid beat (k = 0..PACK_NUM-1) of a word time-major: bit[t*PACK_NUM + k] = i_spikes[t].
REQ-015 SHALL increment the fill counter on each valid beat and wrap it to 0 on the beat with k = PACK_NUM-1.
REQ-016 SHALL push the completed word into the FIFO at the same edge the last beat is captured, giving o_pack_valid high on the next cycle (latency 1 cycle from the last beat).
REQ-017 SHALL clear the assembly register to all zeros whenever a word is pushed or dropped.
REQ-018 SHALL, on i_flush with fill counter > 0, push the partial word with unfilled bits = 0 and reset the fill counter to 0.
REQ-019 SHALL treat i_flush with fill counter = 0 and no valid beat as a no-op.
REQ-020 SHALL, when i_flush and i_spikes_valid coincide, include the beat in the word before flushing, so that exactly one word is pushed even if that beat completes it.
REQ-021 SHALL make the FIFO first-word-fall-through: o_pack_data SHALL equal the oldest entry whenever o_pack_valid = 1.
REQ-022 SHALL, on push with the FIFO full and no pop in that cycle, drop the word, set o_overflow, and keep the FIFO contents unchanged.
REQ-023 SHALL, on simultaneous push and pop with the FIFO full, accept the push with no overflow and leave the count unchanged.
REQ-024 SHALL, on simultaneous push and pop with the FIFO empty, raise o_pack_valid on the next cycle holding the pushed word.
REQ-025 SHALL keep o_pack_data stable while o_pack_valid && !i_pack_ready.
REQ-026 SHALL use wrap-around FIFO pointers with one extra bit to distinguish full from empty.

Reset
REQ-027 SHALL, on s_rst, set o_pack_valid=0, o_overflow=0, o_fill_cnt=0, the FIFO pointers=0, the assembly register=0, and o_pack_data=0.
REQ-028 SHALL make reset dominate i_spikes_valid and i_flush in the same cycle, discarding any partial word and the FIFO contents.
REQ-029 SHALL clear o_overflow only by reset.

Verification
REQ-030 SHALL verify full packing: 16 consecutive beats of i_spikes=4'b1010 with ready=1 -> one word with bits[31:16]=16'hFFFF and bits[63:48]=16'hFFFF, others 0, o_pack_valid for 1 cycle starting the cycle after beat 16.
REQ-031 SHALL verify transposition: a single beat k=3 of i_spikes=4'b0001 then flush -> word = 64'h0000_0000_0000_0008, o_fill_cnt returning to 0.
REQ-032 SHALL verify flush coincident with a 16th beat: 16 beats of 4'hF with i_flush on the last -> exactly one word 64'hFFFF_FFFF_FFFF_FFFF and no extra zero word.
REQ-033 SHALL verify backpressure: ready=0, 5*16 beats -> 4 words held, the 5th dropped, o_overflow=1; with ready=1 afterwards -> the 4 words drain in order and o_overflow stays 1.
REQ-034 SHALL verify full FIFO with pop: FIFO full and ready=1 on the cycle the 5th word completes -> no overflow, 5 words delivered in order.
REQ-035 SHALL verify reset mid-word: 7 beats then s_rst -> o_fill_cnt=0, o_pack_valid=0, and the next 16 beats produce a clean word with no stale bits.
